// File: rtl/print_job_requester.sv
// print_job_requester
//   Requester-side agent for a three-user (B, E, Y) round-robin printer
//   arbiter. Each user has a small job queue and a channel FSM. The FSM
//   raises the user's request and holds it for the job's print length once
//   the arbiter grants it. It then drops the request for one release cycle
//   before it takes the next job.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   job_push   in   enqueue strobe
//   job_user   in   push target: 01=B, 10=E, 11=Y, 00=ignored
//   job_len    in   print length in cycles (0 behaves as 1)
//   job_ready  out  per-user queue not full {B,E,Y}
//   printer    in   arbiter grant code: 00=idle, 01=B, 10=E, 11=Y
//   rb/re/ry   out  request lines, decoded from registered state
//   job_done   out  one-cycle pulse per completed or aborted job
//   done_user  out  user code of the job_done pulse, 00 otherwise
//   starve     out  sticky starvation flags {B,E,Y}
//   err        out  sticky grant-loss / overflow flags {B,E,Y}
module print_job_requester #(
  parameter int LEN_W        = 4,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_push,
  input  logic [1:0]       job_user,
  input  logic [LEN_W-1:0] job_len,
  output logic [2:0]       job_ready,
  input  logic [1:0]       printer,
  output logic             rb,
  output logic             re,
  output logic             ry,
  output logic             job_done,
  output logic [1:0]       done_user,
  output logic [2:0]       starve,
  output logic [2:0]       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [SW-1:0] LIM      = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_PRINT, S_REL} state_t;

  // Index 0 = B, 1 = E, 2 = Y (user code is index + 1).
  logic [2:0] w_req;
  logic [2:0] w_rel;
  logic [2:0] w_sel_oh;

  // Only the lowest-index channel in release reports per cycle; the others
  // stay in release until their turn comes.
  assign w_sel_oh = w_rel & (~w_rel + 3'd1);

  assign job_done  = |w_rel;
  assign done_user = w_rel[0] ? 2'b01 :
                     w_rel[1] ? 2'b10 :
                     w_rel[2] ? 2'b11 : 2'b00;

  assign rb = w_req[0];
  assign re = w_req[1];
  assign ry = w_req[2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      localparam logic [1:0] CODE = 2'(gi + 1);

      logic [LEN_W-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wr;
      logic [PW-1:0]    r_rd;
      logic [PW:0]      r_count;
      state_t           r_state;
      logic [LEN_W-1:0] r_cnt;
      logic [SW-1:0]    r_starve_cnt;
      logic             r_starve;
      logic             r_err;

      logic             w_full;
      logic             w_hit;
      logic             w_push;
      logic             w_pop;
      logic             w_granted;
      logic [LEN_W-1:0] w_head;
      logic [LEN_W-1:0] w_load;
      logic [SW-1:0]    w_starve_inc;

      assign w_full    = (r_count == FULL_CNT);
      assign w_hit     = job_push && (job_user == CODE);
      assign w_push    = w_hit && !w_full;
      assign w_granted = (printer == CODE);
      // The head leaves the queue on normal completion or on grant loss.
      assign w_pop     = (r_state == S_PRINT) && (!w_granted || (r_cnt == '0));
      assign w_head    = r_mem[r_rd];
      // cnt = max(len,1) - 1 so that a zero-length job still prints once.
      assign w_load    = (w_head == '0) ? '0 : w_head - 1'b1;
      assign w_starve_inc = (r_starve_cnt == LIM) ? LIM : r_starve_cnt + 1'b1;

      assign w_req[gi]      = (r_state == S_REQ) || (r_state == S_PRINT);
      assign w_rel[gi]      = (r_state == S_REL);
      assign job_ready[2-gi] = !w_full;
      assign starve[2-gi]    = r_starve;
      assign err[2-gi]       = r_err;

      // Queue storage carries no reset; the pointers define validity.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr] <= job_len;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_wr         <= '0;
          r_rd         <= '0;
          r_count      <= '0;
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_starve_cnt <= '0;
          r_starve     <= 1'b0;
          r_err        <= 1'b0;
        end else begin
          if (w_push) begin
            r_wr <= r_wr + 1'b1;
          end
          if (w_pop) begin
            r_rd <= r_rd + 1'b1;
          end
          r_count <= r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);

          if (w_hit && w_full) begin
            r_err <= 1'b1;
          end

          case (r_state)
            S_IDLE: begin
              if (r_count != '0) begin
                r_state <= S_REQ;
              end
            end
            S_REQ: begin
              if (w_granted) begin
                r_state      <= S_PRINT;
                r_cnt        <= w_load;
                r_starve_cnt <= '0;
              end else begin
                r_starve_cnt <= w_starve_inc;
                if (w_starve_inc == LIM) begin
                  r_starve <= 1'b1;
                end
              end
            end
            S_PRINT: begin
              if (!w_granted) begin
                r_err   <= 1'b1;
                r_state <= S_REL;
              end else if (r_cnt == '0) begin
                r_state <= S_REL;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            S_REL: begin
              if (w_sel_oh[gi]) begin
                r_state <= S_IDLE;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_print_job_requester.sv
module tb_print_job_requester;

  localparam int LEN_W = 4;
  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             job_push = 1'b0;
  logic [1:0]       job_user = 2'b00;
  logic [LEN_W-1:0] job_len = '0;
  logic [1:0]       printer = 2'b00;
  logic [2:0]       job_ready;
  logic             rb, re, ry;
  logic             job_done;
  logic [1:0]       done_user;
  logic [2:0]       starve;
  logic [2:0]       err;

  int n_tests = 0;
  int n_fail  = 0;

  print_job_requester #(.LEN_W(LEN_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .job_push(job_push), .job_user(job_user),
    .job_len(job_len), .job_ready(job_ready), .printer(printer),
    .rb(rb), .re(re), .ry(ry), .job_done(job_done), .done_user(done_user),
    .starve(starve), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: per-user job list plus simple activity flags.
  int mq [3][$];
  bit m_req [3];
  bit m_prt [3];
  bit m_rel [3];
  bit m_starve [3];
  bit m_err [3];
  int m_rem [3];
  int m_wait [3];
  bit auto_arb = 1'b0;
  int last_grant = 2;

  function automatic void model_reset();
    for (int u = 0; u < 3; u++) begin
      mq[u].delete();
      m_req[u] = 0; m_prt[u] = 0; m_rel[u] = 0;
      m_starve[u] = 0; m_err[u] = 0; m_rem[u] = 0; m_wait[u] = 0;
    end
    last_grant = 2;
  endfunction

  function automatic void model_edge();
    int pre_size [3];
    bit rel_pre [3];
    int low;
    int code;
    low = -1;
    for (int u = 0; u < 3; u++) begin
      pre_size[u] = mq[u].size();
      rel_pre[u]  = m_rel[u];
    end
    for (int u = 2; u >= 0; u--) if (rel_pre[u]) low = u;
    for (int u = 0; u < 3; u++) begin
      code = u + 1;
      if (rel_pre[u]) begin
        if (low == u) m_rel[u] = 0;
      end else if (m_prt[u]) begin
        if (int'(printer) != code) begin
          m_err[u] = 1;
          void'(mq[u].pop_front());
          m_prt[u] = 0; m_rel[u] = 1;
        end else begin
          m_rem[u]--;
          if (m_rem[u] == 0) begin
            void'(mq[u].pop_front());
            m_prt[u] = 0; m_rel[u] = 1;
          end
        end
      end else if (m_req[u]) begin
        if (int'(printer) == code) begin
          m_req[u] = 0; m_prt[u] = 1; m_wait[u] = 0;
          m_rem[u] = (mq[u][0] == 0) ? 1 : mq[u][0];
        end else begin
          if (m_wait[u] < LIMIT) m_wait[u]++;
          if (m_wait[u] >= LIMIT) m_starve[u] = 1;
        end
      end else if (pre_size[u] > 0) begin
        m_req[u] = 1;
      end
      if (job_push && int'(job_user) == code) begin
        if (pre_size[u] < DEPTH) mq[u].push_back(int'(job_len));
        else m_err[u] = 1;
      end
    end
  endfunction

  // Legal round-robin arbiter acting on the model's request lines.
  function automatic void arb_update();
    bit r [3];
    int u;
    for (int k = 0; k < 3; k++) r[k] = m_req[k] || m_prt[k];
    if (printer != 2'b00 && r[int'(printer) - 1]) return;
    for (int k = 1; k <= 3; k++) begin
      u = (last_grant + k) % 3;
      if (r[u]) begin
        printer = 2'(u + 1);
        last_grant = u;
        return;
      end
    end
    printer = 2'b00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] e_rdy, e_st, e_er;
    logic [1:0] e_du;
    logic       e_done;
    e_done = 0; e_du = 2'b00; e_rdy = '0; e_st = '0; e_er = '0;
    for (int u = 2; u >= 0; u--) if (m_rel[u]) begin e_done = 1; e_du = 2'(u + 1); end
    for (int u = 0; u < 3; u++) begin
      e_rdy[2-u] = (mq[u].size() < DEPTH);
      e_st[2-u]  = m_starve[u];
      e_er[2-u]  = m_err[u];
    end
    check("rb", 8'(rb), 8'(m_req[0] || m_prt[0]));
    check("re", 8'(re), 8'(m_req[1] || m_prt[1]));
    check("ry", 8'(ry), 8'(m_req[2] || m_prt[2]));
    check("job_done", 8'(job_done), 8'(e_done));
    check("done_user", 8'(done_user), 8'(e_du));
    check("job_ready", 8'(job_ready), 8'(e_rdy));
    check("starve", 8'(starve), 8'(e_st));
    check("err", 8'(err), 8'(e_er));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
    if (auto_arb) arb_update();
  endtask

  task automatic push(input logic [1:0] u, input int len);
    job_push = 1'b1; job_user = u; job_len = LEN_W'(len);
    step();
    job_push = 1'b0; job_user = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b0; job_push = 1'b0; printer = 2'b00;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    int hi;
    int dones;
    logic [5:0] seq;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_ready", 8'(job_ready), 8'h07);
    rst = 1'b1;

    // 1: single B job of length 3 under a legal arbiter
    auto_arb = 1'b1;
    push(2'b01, 3);
    hi = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rb) hi++;
      if (job_done && done_user == 2'b01) dones++;
    end
    check("t1_rb_cycles", 8'(hi), 8'd4);
    check("t1_done", 8'(dones), 8'd1);

    // 2: one job each, round-robin order B,E,Y
    do_reset();
    auto_arb = 1'b1;
    push(2'b01, 2); push(2'b10, 2); push(2'b11, 2);
    dones = 0; seq = '0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (job_done) begin
        seq = {seq[3:0], done_user};
        dones++;
      end
    end
    check("t2_done_cnt", 8'(dones), 8'd3);
    check("t2_done_seq", 8'(seq), 8'b00011011);

    // 3: fill E, overflow with a fifth push, then drain exactly four jobs
    do_reset();
    auto_arb = 1'b0; printer = 2'b00;
    for (int i = 0; i < 4; i++) push(2'b10, $urandom_range(1, 6));
    check("t3_ready_full", 8'(job_ready), 8'b101);
    push(2'b10, 1);
    check("t3_err", 8'(err), 8'b010);
    auto_arb = 1'b1;
    arb_update();
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (job_done && done_user == 2'b10) dones++;
    end
    check("t3_drained", 8'(dones), 8'd4);

    // 4: Y loses its grant mid-print
    do_reset();
    auto_arb = 1'b0; printer = 2'b11;
    push(2'b11, 5);
    step(); step(); step();
    printer = 2'b00;
    step();
    check("t4_err", 8'(err), 8'b001);
    check("t4_done", 8'({job_done, done_user}), 8'b111);
    check("t4_ry", 8'(ry), 8'd0);
    step();
    check("t4_empty", 8'(job_ready), 8'b111);
    check("t4_ry2", 8'(ry), 8'd0);

    // 5: zero-length job prints for one grant cycle
    do_reset();
    auto_arb = 1'b1; printer = 2'b01;
    push(2'b01, 0);
    hi = 0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rb) hi++;
      if (job_done) dones++;
    end
    check("t5_rb_cycles", 8'(hi), 8'd2);
    check("t5_done", 8'(dones), 8'd1);

    // 6: starvation, then asynchronous reset mid-request
    do_reset();
    auto_arb = 1'b0; printer = 2'b00;
    push(2'b01, 1);
    repeat (20) step();
    check("t6_starve", 8'(starve), 8'b100);
    check("t6_rb", 8'(rb), 8'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_rb", 8'(rb), 8'd0);
    check("t6_rst_starve", 8'(starve), 8'd0);
    check("t6_rst_ready", 8'(job_ready), 8'b111);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic with occasional illegal grant changes
    auto_arb = 1'b1; printer = 2'b00;
    for (int i = 0; i < 500; i++) begin
      job_push = ($urandom_range(0, 2) == 0);
      job_user = 2'($urandom_range(0, 3));
      job_len  = LEN_W'($urandom_range(0, 7));
      step();
      if ($urandom_range(0, 9) == 0) printer = 2'($urandom_range(0, 3));
    end
    job_push = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
